// File: rtl/riscv_mem_arb_pkg.sv
// Shared encodings and helpers for the memory-port arbiter.
package riscv_mem_arb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

    // A fetch is always a full-word read.
    localparam logic [3:0] FETCH_BE = 4'hF;

    // Request as latched on acceptance and replayed onto the bus.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [3:0]  be;
        logic        owner;
    } bus_req_t;

    // Bits needed to hold values 0..max_val (never less than one bit).
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/riscv_mem_arb_sel.sv
// Winner selection between fetch and load/store, with an anti-starvation
// count that lets a waiting fetch through after STARVE_MAX back-to-back
// load/store grants.
module riscv_mem_arb_sel
    import riscv_mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_rdy,
    input  logic ls_rdy,
    input  logic grant_en,
    output logic if_win,
    output logic ls_win
);

    localparam int SW = cnt_w(STARVE_MAX);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    logic          if_forced;

    // Load/store wins ties unless fetch has waited through STARVE_MAX grants.
    always_comb begin
        if_forced = (STARVE_MAX != 0) && (starve_cnt_q == STARVE_LIM);
        if_win    = if_rdy && (!ls_rdy || if_forced);
        ls_win    = ls_rdy && !if_win;
    end

    // Count load/store grants taken while fetch waited; saturate at the limit.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (grant_en) begin
            if (if_win) begin
                starve_cnt_d = '0;
            end else if (ls_win) begin
                if (!if_rdy) begin
                    starve_cnt_d = '0;
                end else if (starve_cnt_q != STARVE_LIM) begin
                    starve_cnt_d = starve_cnt_q + 1'b1;
                end
            end
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/riscv_mem_arb.sv
// Shared memory port arbiter: grants fetch or load/store, runs one bus
// transaction at a time and returns a registered response pulse to its owner.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no transaction; winner is acked and its request latched
//   ST_ISSUE | bus_rdy high with latched request, waiting for bus_ack
//   ST_WAIT  | request accepted by the bus, waiting for bus_resp_rdy
//
// ISSUE and WAIT share one timeout counter; expiry returns to IDLE with an
// error response unless a completion lands in the same cycle.
module riscv_mem_arb
    import riscv_mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_rdy,
    output logic        if_ack,
    input  logic [31:0] if_addr,
    output logic        if_resp_rdy,
    output logic [31:0] if_resp_data,
    output logic        if_resp_err,
    input  logic        ls_rdy,
    output logic        ls_ack,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    input  logic        ls_we,
    input  logic [3:0]  ls_be,
    output logic        ls_resp_rdy,
    output logic [31:0] ls_resp_data,
    output logic        ls_resp_err,
    output logic        bus_rdy,
    input  logic        bus_ack,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_we,
    output logic [3:0]  bus_be,
    input  logic        bus_resp_rdy,
    input  logic [31:0] bus_resp_data
);

    localparam int TW = cnt_w(TIMEOUT - 1);
    localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);

    logic [1:0]    state_q, state_d;
    bus_req_t      req_q, req_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          if_resp_rdy_q, if_resp_rdy_d;
    logic          ls_resp_rdy_q, ls_resp_rdy_d;
    logic [31:0]   resp_data_q, resp_data_d;
    logic          resp_err_q, resp_err_d;
    logic          grant_en, if_win, ls_win;
    logic          complete, expire;

    assign grant_en = (state_q == ST_IDLE);
    assign if_ack   = grant_en & if_win;
    assign ls_ack   = grant_en & ls_win;

    riscv_mem_arb_sel #(
        .STARVE_MAX (STARVE_MAX)
    ) u_sel (
        .clk      (clk),
        .rst      (rst),
        .if_rdy   (if_rdy),
        .ls_rdy   (ls_rdy),
        .grant_en (grant_en),
        .if_win   (if_win),
        .ls_win   (ls_win)
    );

    assign bus_rdy   = (state_q == ST_ISSUE);
    assign bus_addr  = req_q.addr;
    assign bus_wdata = req_q.wdata;
    assign bus_we    = req_q.we;
    assign bus_be    = req_q.be;

    // Response data/err are only visible to the owner during its pulse.
    assign if_resp_rdy  = if_resp_rdy_q;
    assign if_resp_data = if_resp_rdy_q ? resp_data_q : '0;
    assign if_resp_err  = if_resp_rdy_q & resp_err_q;
    assign ls_resp_rdy  = ls_resp_rdy_q;
    assign ls_resp_data = ls_resp_rdy_q ? resp_data_q : '0;
    assign ls_resp_err  = ls_resp_rdy_q & resp_err_q;

    // Sequencer: latch on grant, drive the bus, finish on response or timeout.
    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        tcnt_d        = tcnt_q;
        if_resp_rdy_d = 1'b0;
        ls_resp_rdy_d = 1'b0;
        resp_data_d   = '0;
        resp_err_d    = 1'b0;
        complete      = 1'b0;
        expire        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (if_win) begin
                    req_d   = '{addr: if_addr, wdata: 32'h0, we: 1'b0,
                                be: FETCH_BE, owner: OWN_IF};
                    state_d = ST_ISSUE;
                    tcnt_d  = '0;
                end else if (ls_win) begin
                    req_d   = '{addr: ls_addr, wdata: ls_wdata, we: ls_we,
                                be: ls_be, owner: OWN_LS};
                    state_d = ST_ISSUE;
                    tcnt_d  = '0;
                end
            end
            ST_ISSUE: begin
                complete = bus_ack && bus_resp_rdy;
                if (bus_ack && !bus_resp_rdy) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                complete = bus_resp_rdy;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_q == ST_ISSUE || state_q == ST_WAIT) begin
            tcnt_d = tcnt_q + 1'b1;
            expire = !complete && (tcnt_q == TCNT_LAST);
            if (complete || expire) begin
                state_d       = ST_IDLE;
                if_resp_rdy_d = (req_q.owner == OWN_IF);
                ls_resp_rdy_d = (req_q.owner == OWN_LS);
                resp_err_d    = expire;
                resp_data_d   = (complete && !req_q.we) ? bus_resp_data : 32'h0;
            end
        end
    end

    // State, latched request, timer and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            req_q         <= '0;
            tcnt_q        <= '0;
            if_resp_rdy_q <= 1'b0;
            ls_resp_rdy_q <= 1'b0;
            resp_data_q   <= '0;
            resp_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_q         <= req_d;
            tcnt_q        <= tcnt_d;
            if_resp_rdy_q <= if_resp_rdy_d;
            ls_resp_rdy_q <= ls_resp_rdy_d;
            resp_data_q   <= resp_data_d;
            resp_err_q    <= resp_err_d;
        end
    end

endmodule

// File: tb/tb_riscv_mem_arb.sv
// Self-checking bench for riscv_mem_arb: directed table, corner sequences,
// then randomized traffic against a transaction-level reference model.
module tb_riscv_mem_arb;

    localparam int STARVE_MAX = 4;
    localparam int TIMEOUT    = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_rdy, if_ack, if_resp_rdy, if_resp_err;
    logic [31:0] if_addr, if_resp_data;
    logic        ls_rdy, ls_ack, ls_we, ls_resp_rdy, ls_resp_err;
    logic [31:0] ls_addr, ls_wdata, ls_resp_data;
    logic [3:0]  ls_be;
    logic        bus_rdy, bus_ack, bus_we, bus_resp_rdy;
    logic [31:0] bus_addr, bus_wdata, bus_resp_data;
    logic [3:0]  bus_be;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    riscv_mem_arb #(
        .STARVE_MAX (STARVE_MAX),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .if_rdy        (if_rdy),
        .if_ack        (if_ack),
        .if_addr       (if_addr),
        .if_resp_rdy   (if_resp_rdy),
        .if_resp_data  (if_resp_data),
        .if_resp_err   (if_resp_err),
        .ls_rdy        (ls_rdy),
        .ls_ack        (ls_ack),
        .ls_addr       (ls_addr),
        .ls_wdata      (ls_wdata),
        .ls_we         (ls_we),
        .ls_be         (ls_be),
        .ls_resp_rdy   (ls_resp_rdy),
        .ls_resp_data  (ls_resp_data),
        .ls_resp_err   (ls_resp_err),
        .bus_rdy       (bus_rdy),
        .bus_ack       (bus_ack),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_we        (bus_we),
        .bus_be        (bus_be),
        .bus_resp_rdy  (bus_resp_rdy),
        .bus_resp_data (bus_resp_data)
    );

    typedef struct {
        logic        if_rdy, ls_rdy, bus_ack, bus_resp_rdy;
        logic [31:0] resp_data;
        logic        e_if_ack, e_ls_ack, e_bus_rdy;
        logic [31:0] e_addr, e_wdata;
        logic        e_we;
        logic [3:0]  e_be;
        logic        e_if_resp, e_ls_resp;
        logic [31:0] e_data;
        logic        e_err;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_bus(input logic e_rdy, input logic [31:0] e_addr,
                           input logic [31:0] e_wdata, input logic e_we, input logic [3:0] e_be);
        chk1("bus_rdy", bus_rdy, e_rdy);
        if (e_rdy) begin
            chk("bus_addr", bus_addr, e_addr);
            chk("bus_wdata", bus_wdata, e_wdata);
            chk1("bus_we", bus_we, e_we);
            chk("bus_be", {28'h0, bus_be}, {28'h0, e_be});
        end
    endtask

    task automatic chk_resp(input logic e_if, input logic e_ls, input logic [31:0] e_data, input logic e_err);
        chk1("if_resp_rdy", if_resp_rdy, e_if);
        chk1("ls_resp_rdy", ls_resp_rdy, e_ls);
        chk("if_resp_data", if_resp_data, e_if ? e_data : 32'h0);
        chk1("if_resp_err", if_resp_err, e_if & e_err);
        chk("ls_resp_data", ls_resp_data, e_ls ? e_data : 32'h0);
        chk1("ls_resp_err", ls_resp_err, e_ls & e_err);
    endtask

    task automatic chk_zero(input string tag);
        chk1({tag, "_if_ack"}, if_ack, 1'b0);
        chk1({tag, "_ls_ack"}, ls_ack, 1'b0);
        chk1({tag, "_bus_rdy"}, bus_rdy, 1'b0);
        chk({tag, "_bus_addr"}, bus_addr, 32'h0);
        chk({tag, "_bus_wdata"}, bus_wdata, 32'h0);
        chk1({tag, "_bus_we"}, bus_we, 1'b0);
        chk({tag, "_bus_be"}, {28'h0, bus_be}, 32'h0);
        chk_resp(1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic clear_inputs();
        if_rdy = 1'b0; if_addr = 32'h0;
        ls_rdy = 1'b0; ls_addr = 32'h0; ls_wdata = 32'h0; ls_we = 1'b0; ls_be = 4'h0;
        bus_ack = 1'b0; bus_resp_rdy = 1'b0; bus_resp_data = 32'h0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    // Reference model state (transaction level).
    bit          m_busy, m_acc, m_own_ls, m_we;
    int          m_age, m_starve;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_be;
    bit          m_rif, m_rls, m_rerr;
    logic [31:0] m_rdata;

    initial begin
        // Expected ls,ls,ls,ls,if repeating (1 = ls)
        bit exp_ls[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        int grants;

        //           if   ls   back rrdy rdata          ifak lsak brdy addr      wdata          we   be       ifr  lsr  data           err
        tbl[0] = '{1'b1,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b0,1'b0,32'h0,    32'h0,        1'b0,4'h0,    1'b0,1'b0,32'h0,        1'b0};
        tbl[1] = '{1'b0,1'b0,1'b1,1'b0,32'h0,        1'b0,1'b0,1'b1,32'h100,  32'h0,        1'b0,4'hF,    1'b0,1'b0,32'h0,        1'b0};
        tbl[2] = '{1'b0,1'b0,1'b0,1'b1,32'hDEADBEEF, 1'b0,1'b0,1'b0,32'h0,    32'h0,        1'b0,4'h0,    1'b0,1'b0,32'h0,        1'b0};
        tbl[3] = '{1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,32'h0,    32'h0,        1'b0,4'h0,    1'b1,1'b0,32'hDEADBEEF, 1'b0};
        tbl[4] = '{1'b0,1'b1,1'b0,1'b0,32'h0,        1'b0,1'b1,1'b0,32'h0,    32'h0,        1'b0,4'h0,    1'b0,1'b0,32'h0,        1'b0};
        tbl[5] = '{1'b0,1'b0,1'b1,1'b1,32'hCAFEF00D, 1'b0,1'b0,1'b1,32'h20,   32'h11223344, 1'b1,4'b0011, 1'b0,1'b0,32'h0,        1'b0};
        tbl[6] = '{1'b1,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b0,1'b0,32'h0,    32'h0,        1'b0,4'h0,    1'b0,1'b1,32'h0,        1'b0};
        tbl[7] = '{1'b0,1'b0,1'b1,1'b1,32'h12345678, 1'b0,1'b0,1'b1,32'h100,  32'h0,        1'b0,4'hF,    1'b0,1'b0,32'h0,        1'b0};
        tbl[8] = '{1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,32'h0,    32'h0,        1'b0,4'h0,    1'b1,1'b0,32'h12345678, 1'b0};

        // ---- reset state ----
        do_reset();
        @(negedge clk);
        chk_zero("reset");
        next_cycle();

        // ---- directed table: lone fetch, store, back-to-back fetch ----
        if_addr = 32'h100; ls_addr = 32'h20; ls_wdata = 32'h11223344; ls_we = 1'b1; ls_be = 4'b0011;
        for (int i = 0; i < 9; i++) begin
            if_rdy        = tbl[i].if_rdy;
            ls_rdy        = tbl[i].ls_rdy;
            bus_ack       = tbl[i].bus_ack;
            bus_resp_rdy  = tbl[i].bus_resp_rdy;
            bus_resp_data = tbl[i].resp_data;
            @(negedge clk);
            chk1("tbl_if_ack", if_ack, tbl[i].e_if_ack);
            chk1("tbl_ls_ack", ls_ack, tbl[i].e_ls_ack);
            chk_bus(tbl[i].e_bus_rdy, tbl[i].e_addr, tbl[i].e_wdata, tbl[i].e_we, tbl[i].e_be);
            chk_resp(tbl[i].e_if_resp, tbl[i].e_ls_resp, tbl[i].e_data, tbl[i].e_err);
            next_cycle();
        end

        // ---- starvation: both requesting, zero-latency bus ----
        do_reset();
        if_rdy = 1'b1; if_addr = 32'h400; ls_rdy = 1'b1; ls_addr = 32'h800; ls_we = 1'b0; ls_be = 4'hF;
        grants = 0;
        for (int c = 0; c < 60 && grants < 10; c++) begin
            bus_ack = 1'b1; bus_resp_rdy = 1'b1; bus_resp_data = 32'(c);
            @(negedge clk);
            chk1("starve_one_hot", if_ack & ls_ack, 1'b0);
            if (if_ack || ls_ack) begin
                chk1("starve_order", ls_ack, exp_ls[grants]);
                grants++;
            end
            next_cycle();
        end
        chk("starve_grants", grants, 10);

        // ---- timeout: bus never responds ----
        do_reset();
        ls_rdy = 1'b1; ls_addr = 32'h40; ls_we = 1'b0; ls_be = 4'hF;
        bus_resp_data = 32'hBAD0BAD0;
        @(negedge clk);
        chk1("to_ack", ls_ack, 1'b1);
        next_cycle();
        ls_rdy = 1'b0;
        for (int c = 1; c <= TIMEOUT; c++) begin
            @(negedge clk);
            chk1("to_bus_rdy_high", bus_rdy, 1'b1);
            chk_resp(1'b0, 1'b0, 32'h0, 1'b0);
            next_cycle();
        end
        if_rdy = 1'b1; if_addr = 32'h200;
        @(negedge clk);
        chk1("to_bus_rdy_low", bus_rdy, 1'b0);
        chk_resp(1'b0, 1'b1, 32'h0, 1'b1);
        chk1("to_next_ack", if_ack, 1'b1);
        next_cycle();
        if_rdy = 1'b0; bus_ack = 1'b1; bus_resp_rdy = 1'b1; bus_resp_data = 32'h55;
        @(negedge clk);
        chk_bus(1'b1, 32'h200, 32'h0, 1'b0, 4'hF);
        next_cycle();
        bus_ack = 1'b0; bus_resp_rdy = 1'b0;
        @(negedge clk);
        chk_resp(1'b1, 1'b0, 32'h55, 1'b0);
        next_cycle();

        // ---- completion on the expiry cycle (from WAIT, then from ISSUE) ----
        for (int v = 0; v < 2; v++) begin
            do_reset();
            if_rdy = 1'b1; if_addr = 32'h300 + 32'(v);
            @(negedge clk);
            chk1("exp_ack", if_ack, 1'b1);
            next_cycle();
            if_rdy = 1'b0;
            for (int c = 1; c <= TIMEOUT; c++) begin
                bus_ack       = (v == 0) ? (c == 1) : (c == TIMEOUT);
                bus_resp_rdy  = (c == TIMEOUT);
                bus_resp_data = 32'hA5A50000 + 32'(v);
                @(negedge clk);
                chk1("exp_bus_rdy", bus_rdy, (v == 1) || (c == 1));
                chk_resp(1'b0, 1'b0, 32'h0, 1'b0);
                next_cycle();
            end
            bus_ack = 1'b0; bus_resp_rdy = 1'b0;
            @(negedge clk);
            chk_resp(1'b1, 1'b0, 32'hA5A50000 + 32'(v), 1'b0);
            next_cycle();
        end

        // ---- reset while in WAIT ----
        do_reset();
        ls_rdy = 1'b1; ls_addr = 32'h60; ls_wdata = 32'h77; ls_we = 1'b0; ls_be = 4'h3;
        @(negedge clk);
        chk1("rw_ack", ls_ack, 1'b1);
        next_cycle();
        ls_rdy = 1'b0; bus_ack = 1'b1;
        next_cycle();
        bus_ack = 1'b0; rst = 1'b1;
        next_cycle();
        rst = 1'b0; bus_resp_rdy = 1'b1; bus_resp_data = 32'h99;
        @(negedge clk);
        chk_zero("rw_after");
        next_cycle();
        bus_resp_rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk_resp(1'b0, 1'b0, 32'h0, 1'b0);
            chk1("rw_bus_rdy", bus_rdy, 1'b0);
            next_cycle();
        end

        // ---- randomized traffic against the reference model ----
        do_reset();
        m_busy = 0; m_acc = 0; m_age = 0; m_starve = 0; m_own_ls = 0;
        m_addr = 0; m_wdata = 0; m_we = 0; m_be = 0;
        m_rif = 0; m_rls = 0; m_rdata = 0; m_rerr = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit e_if_ack, e_ls_ack, done;
            if (!if_rdy && $urandom_range(0, 2) == 0) begin
                if_rdy = 1'b1; if_addr = $urandom;
            end
            if (!ls_rdy && $urandom_range(0, 2) == 0) begin
                ls_rdy = 1'b1; ls_addr = $urandom; ls_wdata = $urandom;
                ls_we = 1'($urandom_range(0, 1)); ls_be = 4'($urandom_range(0, 15));
            end
            bus_ack = 1'b0; bus_resp_rdy = 1'b0; bus_resp_data = $urandom;
            if (m_busy && !m_acc) begin
                bus_ack = 1'($urandom_range(0, 1));
                bus_resp_rdy = bus_ack && ($urandom_range(0, 2) == 0);
            end else if (m_busy) begin
                bus_resp_rdy = ($urandom_range(0, 3) == 0);
            end else begin
                bus_resp_rdy = ($urandom_range(0, 7) == 0);
            end

            e_if_ack = 0; e_ls_ack = 0;
            if (!m_busy) begin
                if (if_rdy && (!ls_rdy || (STARVE_MAX > 0 && m_starve >= STARVE_MAX)))
                    e_if_ack = 1;
                else if (ls_rdy)
                    e_ls_ack = 1;
            end

            @(negedge clk);
            chk1("rnd_if_ack", if_ack, e_if_ack);
            chk1("rnd_ls_ack", ls_ack, e_ls_ack);
            chk_bus(m_busy && !m_acc, m_addr, m_wdata, m_we, m_be);
            chk_resp(m_rif, m_rls, m_rdata, m_rerr);

            m_rif = 0; m_rls = 0; m_rdata = 0; m_rerr = 0;
            if (m_busy) begin
                done = m_acc ? bus_resp_rdy : (bus_ack && bus_resp_rdy);
                if (done || m_age == TIMEOUT - 1) begin
                    m_busy  = 0;
                    m_rif   = !m_own_ls;
                    m_rls   = m_own_ls;
                    m_rerr  = !done;
                    m_rdata = (done && !m_we) ? bus_resp_data : 32'h0;
                end else begin
                    if (bus_ack) m_acc = 1;
                    m_age++;
                end
            end else if (e_if_ack || e_ls_ack) begin
                m_busy = 1; m_acc = 0; m_age = 0; m_own_ls = e_ls_ack;
                if (e_if_ack) begin
                    m_addr = if_addr; m_wdata = 32'h0; m_we = 0; m_be = 4'hF;
                    m_starve = 0;
                end else begin
                    m_addr = ls_addr; m_wdata = ls_wdata; m_we = ls_we; m_be = ls_be;
                    m_starve = if_rdy ? ((m_starve + 1 > STARVE_MAX) ? STARVE_MAX : m_starve + 1) : 0;
                end
            end

            next_cycle();
            if (e_if_ack) if_rdy = 1'b0;
            if (e_ls_ack) ls_rdy = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/riscv_mem_arb.md
Name: riscv_mem_arb

Overview:
Arbiter and sequencer for the single shared memory port. It serves two requesters: instruction fetch (if) and the load/store path of the MEM stage (ls).
- Grants one requester at a time and drives the bus with a rdy/ack handshake.
- Tracks the single outstanding transaction and routes its response back to the owner.
- Aborts a transaction with an error response on timeout.

Parameters:
STARVE_MAX, 4, max consecutive ls grants while if is waiting before if wins one grant; 0 = ls always wins
TIMEOUT, 64, cycles from entering ISSUE until the transaction is abandoned with error; must be >= 2

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset, synchronous, active-high
if_rdy  in  1  fetch request valid
if_ack  out  1  fetch request accepted this cycle
if_addr  in  32  fetch address
if_resp_rdy  out  1  one-cycle fetch response pulse
if_resp_data  out  32  fetch read data
if_resp_err  out  1  fetch response is timeout error
ls_rdy  in  1  load/store request valid
ls_ack  out  1  load/store request accepted this cycle
ls_addr  in  32  load/store address
ls_wdata  in  32  store data
ls_we  in  1  1 = store
ls_be  in  4  byte enables
ls_resp_rdy  out  1  one-cycle load/store response pulse
ls_resp_data  out  32  load data (0 for stores)
ls_resp_err  out  1  load/store response is timeout error
bus_rdy  out  1  bus request valid
bus_ack  in  1  bus accepted request
bus_addr  out  32  latched address
bus_wdata  out  32  latched write data
bus_we  out  1  latched write enable (0 for fetch)
bus_be  out  4  latched byte enables (4'hF for fetch)
bus_resp_rdy  in  1  bus response valid
bus_resp_data  in  32  bus read data

Behaviour:
- Reset: all outputs 0, state IDLE, starvation and timeout counters 0. Reset mid-transaction abandons it; no response pulse is issued.
- States: IDLE, ISSUE, WAIT.
- IDLE: *_ack is combinational, asserted only in IDLE, for the winner only. On ack, latch the request (bus_* fields, owner) and move to ISSUE. Requesters hold *_rdy and fields until acked.
- Selection when both requesting:
  - ls wins unless STARVE_MAX != 0 and starve_cnt == STARVE_MAX; then if wins.
  - starve_cnt increments on an ls grant with if_rdy high and saturates at STARVE_MAX.
  - starve_cnt clears on any if grant, or on an ls grant with if_rdy low.
  - A lone requester always wins.
- ISSUE: bus_rdy=1 with latched fields.
  - bus_ack & bus_resp_rdy: complete -> IDLE.
  - bus_ack only: -> WAIT.
- WAIT: bus_rdy=0. bus_resp_rdy: complete -> IDLE.
- Timeout:
  - tcnt clears on ISSUE entry and increments each cycle in ISSUE/WAIT.
  - If tcnt == TIMEOUT-1 with no completion that cycle: drop bus_rdy, -> IDLE, issue error response.
  - A completion in the same cycle as expiry takes precedence over the error.
- Response:
  - Registered: owner's *_resp_rdy pulses exactly 1 cycle after the completion/timeout cycle.
  - *_resp_data = bus_resp_data captured on completion; 0 on timeout or store.
  - *_resp_err = 1 only on timeout.
  - The non-owner's resp outputs stay 0.
- bus_resp_rdy in IDLE is ignored. Slaves must not respond after timeout.
- Throughput: new ack is allowed in the IDLE cycle coinciding with the previous response pulse. Minimum 2 cycles per transaction (IDLE, ISSUE with ack+resp).

Decomposition:
- Package riscv_mem_arb_pkg:
  - state encoding (ST_IDLE, ST_ISSUE, ST_WAIT)
  - owner encoding (OWN_IF, OWN_LS)
  - FETCH_BE = 4'hF
  - counter width functions via $clog2
- Sub-module riscv_mem_arb_sel: combinational winner select plus starve_cnt register, with inputs if_rdy, ls_rdy, grant_en.

Test Plan:
- Lone fetch 0x100, bus_ack and bus_resp_rdy=0xDEADBEEF one cycle later -> if_ack cycle 0, bus_rdy cycle 1, if_resp_rdy cycle 3 with data 0xDEADBEEF, err=0.
- Both requesting continuously, STARVE_MAX=4, zero-latency bus -> grant order ls,ls,ls,ls,if repeating.
- Store ls_addr 0x20, wdata 0x11223344, be 4'b0011 -> bus_we=1, bus_be=4'b0011, ls_resp_data=0.
- Bus never responds, TIMEOUT=8 -> bus_rdy drops after 8 cycles in ISSUE; owner resp pulse with err=1, data=0; next request accepted.
- Response arriving on the expiry cycle -> normal data response, err=0.
- rst asserted while in WAIT -> next cycle all outputs 0, IDLE; a later bus_resp_rdy is ignored, no resp pulse.
